// File: rtl/regfile_scoreboard.sv
// Register file (x0 = 0) with per-register pending-producer counters for issue hazard tracking.
// Reads and busy are combinational. Issue stalls via issue_ready once a counter saturates.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int PW     = 2,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  input  logic            flush
);

  localparam logic [PW-1:0] PMAX = '1;
  localparam logic [PW-1:0] PONE = PW'(1);

  logic [XLEN-1:0] regs [NREG];
  logic [PW-1:0]   pend [NREG];

  logic wr_en;
  logic hs;

  assign wr_en       = we && (rd != '0);
  assign issue_ready = (issue_rd == '0) || (pend[issue_rd] != PMAX);
  assign hs          = issue_valid && issue_ready && (issue_rd != '0);

  // A writeback to a source retiring its last producer clears busy in the same cycle only when
  // the data is forwarded; without bypass the consumer must wait for the register update.
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = (pend[rs1] != '0);
    busy2 = (pend[rs2] != '0);
    if (rs1 != '0) begin
      if ((BYPASS != 0) && wr_en && (rd == rs1)) rd1 = wd;
      else                                       rd1 = regs[rs1];
    end
    if (rs2 != '0) begin
      if ((BYPASS != 0) && wr_en && (rd == rs2)) rd2 = wd;
      else                                       rd2 = regs[rs2];
    end
    if ((BYPASS != 0) && wr_en && (rd == rs1) && (pend[rs1] == PONE)) busy1 = 1'b0;
    if ((BYPASS != 0) && wr_en && (rd == rs2) && (pend[rs2] == PONE)) busy2 = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      if (wr_en) regs[rd] <= wd;
      // pend[0] is never touched after reset, so it stays zero.
      for (int i = 1; i < NREG; i++) begin
        if (flush) begin
          pend[i] <= '0;
        end else if (hs && (issue_rd == AW'(i))) begin
          if (!(wr_en && (rd == AW'(i)))) pend[i] <= pend[i] + PONE;
        end else if (wr_en && (rd == AW'(i)) && (pend[i] != '0)) begin
          pend[i] <= pend[i] - PONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, async-reset check, random vs. reference model.
module tb_regfile_scoreboard;

  logic        clk, rst_n;
  logic        we, issue_valid, flush;
  logic [4:0]  rd, rs1, rs2, issue_rd;
  logic [31:0] wd;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy1, busy2, issue_ready;
  logic        busy1_nb, busy2_nb, issue_ready_nb;

  int tests  = 0;
  int errors = 0;

  regfile_scoreboard #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .rd(rd), .wd(wd), .rs1(rs1), .rs2(rs2),
    .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready), .flush(flush)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .rd(rd), .wd(wd), .rs1(rs1), .rs2(rs2),
    .rd1(rd1_nb), .rd2(rd2_nb), .busy1(busy1_nb), .busy2(busy2_nb),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready_nb), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: architectural register values and outstanding-producer counts.
  int unsigned m_reg  [32];
  int          m_pend [32];

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1, rs2;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] e_rd1, e_rd2;
    logic        e_b1, e_b2, e_rdy;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 0;
      m_pend[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit hs, wb;
    hs = issue_valid && (issue_rd != 0) && (m_pend[issue_rd] < 3);
    wb = we && (rd != 0);
    if (wb) m_reg[rd] = wd;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end else if (!(hs && wb && issue_rd == rd)) begin
      if (hs) m_pend[issue_rd] = m_pend[issue_rd] + 1;
      if (wb && m_pend[rd] > 0) m_pend[rd] = m_pend[rd] - 1;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] rs, input bit byp);
    if (rs == 0) return 32'h0;
    if (byp && we && rd == rs) return wd;
    return m_reg[rs];
  endfunction

  function automatic logic m_busy(input logic [4:0] rs, input bit byp);
    if (m_pend[rs] == 0) return 1'b0;
    if (byp && we && rd == rs && m_pend[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive(input vec_t v);
    we = v.we; rd = v.rd; wd = v.wd; rs1 = v.rs1; rs2 = v.rs2;
    issue_valid = v.iv; issue_rd = v.ird; flush = v.fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_vec(input int i, input logic w, input logic [4:0] d, input logic [31:0] data,
                         input logic [4:0] s1, input logic [4:0] s2, input logic iv,
                         input logic [4:0] ir, input logic f, input logic [31:0] e1,
                         input logic [31:0] e2, input logic b1, input logic b2, input logic rdy);
    vecs[i] = '{w, d, data, s1, s2, iv, ir, f, e1, e2, b1, b2, rdy};
  endtask

  initial begin
    set_vec( 0, 0, 0, 0,            5, 31, 0, 0, 0, 0,            0,            0, 0, 1);
    set_vec( 1, 1, 1, 32'hDEADBEEF, 1, 0,  0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 1);
    set_vec( 2, 0, 0, 0,            1, 0,  0, 0, 0, 32'hDEADBEEF, 0,            0, 0, 1);
    set_vec( 3, 1, 0, 32'hCAFEBABE, 0, 1,  0, 0, 0, 0,            32'hDEADBEEF, 0, 0, 1);
    set_vec( 4, 0, 0, 0,            0, 1,  0, 0, 0, 0,            32'hDEADBEEF, 0, 0, 1);
    set_vec( 5, 0, 0, 0,            3, 0,  1, 3, 0, 0,            0,            0, 0, 1);
    set_vec( 6, 0, 0, 0,            3, 0,  1, 3, 0, 0,            0,            1, 0, 1);
    set_vec( 7, 0, 0, 0,            3, 0,  1, 3, 0, 0,            0,            1, 0, 1);
    set_vec( 8, 0, 0, 0,            3, 0,  1, 3, 0, 0,            0,            1, 0, 0);
    set_vec( 9, 0, 0, 0,            3, 0,  0, 3, 0, 0,            0,            1, 0, 0);
    set_vec(10, 1, 3, 32'h33,       3, 0,  0, 0, 0, 32'h33,       0,            1, 0, 1);
    set_vec(11, 1, 3, 32'h34,       3, 0,  0, 0, 0, 32'h34,       0,            1, 0, 1);
    set_vec(12, 1, 3, 32'h35,       3, 0,  0, 0, 0, 32'h35,       0,            0, 0, 1);
    set_vec(13, 0, 0, 0,            3, 0,  0, 0, 0, 32'h35,       0,            0, 0, 1);
    set_vec(14, 0, 0, 0,            4, 0,  1, 4, 0, 0,            0,            0, 0, 1);
    set_vec(15, 1, 4, 32'h44444444, 4, 0,  1, 4, 0, 32'h44444444, 0,            0, 0, 1);
    set_vec(16, 0, 0, 0,            4, 0,  0, 0, 0, 32'h44444444, 0,            1, 0, 1);
    set_vec(17, 0, 0, 0,            2, 7,  1, 2, 0, 0,            0,            0, 0, 1);
    set_vec(18, 0, 0, 0,            2, 7,  1, 2, 0, 0,            0,            1, 0, 1);
    set_vec(19, 0, 0, 0,            2, 7,  1, 7, 0, 0,            0,            1, 0, 1);
    set_vec(20, 0, 0, 0,            2, 7,  1, 2, 1, 0,            0,            1, 1, 1);
    set_vec(21, 0, 0, 0,            2, 4,  0, 0, 0, 0,            32'h44444444, 0, 0, 1);
    set_vec(22, 1, 5, 32'h55,       5, 0,  0, 0, 0, 32'h55,       0,            0, 0, 1);
    set_vec(23, 0, 0, 0,            5, 0,  1, 5, 0, 32'h55,       0,            0, 0, 1);
    set_vec(24, 0, 0, 0,            5, 0,  0, 0, 0, 32'h55,       0,            1, 0, 1);
    set_vec(25, 0, 0, 0,            0, 0,  1, 0, 0, 0,            0,            0, 0, 1);

    rst_n = 1'b0;
    we = 1'b1; rd = 5'd9; wd = 32'h12345678; rs1 = 5'd9; rs2 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd9; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs[0].we = 1'b0;
    we = 1'b0; issue_valid = 1'b0; rs1 = 5'd5; rs2 = 5'd31; issue_rd = 5'd0;
    #1;
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_rd2", rd2, 32'h0);
    chk("reset_busy1", {31'b0, busy1}, 32'h0);
    chk("reset_busy2", {31'b0, busy2}, 32'h0);
    chk("reset_ready", {31'b0, issue_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].e_rd1);
      chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].e_rd2);
      chk($sformatf("vec%0d_busy1", i), {31'b0, busy1}, {31'b0, vecs[i].e_b1});
      chk($sformatf("vec%0d_busy2", i), {31'b0, busy2}, {31'b0, vecs[i].e_b2});
      chk($sformatf("vec%0d_ready", i), {31'b0, issue_ready}, {31'b0, vecs[i].e_rdy});
      tick();
    end

    // Async reset between edges: outputs must clear before any clock edge.
    we = 1'b1; rd = 5'd6; wd = 32'hA5A5A5A5; rs1 = 5'd1; rs2 = 5'd5;
    issue_valid = 1'b1; issue_rd = 5'd5; flush = 1'b0;
    #1;
    chk("pre_reset_rd1", rd1, 32'hDEADBEEF);
    chk("pre_reset_busy2", {31'b0, busy2}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rd1", rd1, 32'h0);
    chk("async_rd2", rd2, 32'h0);
    chk("async_busy2", {31'b0, busy2}, 32'h0);
    chk("async_ready", {31'b0, issue_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rs1 = 5'd6;
    we = 1'b0; issue_valid = 1'b0;
    #1;
    chk("inflight_discard_rd1", rd1, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 3000; n++) begin
      we          = ($urandom_range(0, 1) == 1);
      rd          = 5'($urandom_range(0, 7));
      wd          = $urandom;
      rs1         = 5'($urandom_range(0, 7));
      rs2         = (n % 16 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_rd    = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 39) == 0);
      #1;
      chk("rnd_rd1", rd1, m_read(rs1, 1));
      chk("rnd_rd2", rd2, m_read(rs2, 1));
      chk("rnd_busy1", {31'b0, busy1}, {31'b0, m_busy(rs1, 1)});
      chk("rnd_busy2", {31'b0, busy2}, {31'b0, m_busy(rs2, 1)});
      chk("rnd_ready", {31'b0, issue_ready},
          {31'b0, (issue_rd == 0) || (m_pend[issue_rd] < 3)});
      chk("rnd_nb_rd1", rd1_nb, m_read(rs1, 0));
      chk("rnd_nb_rd2", rd2_nb, m_read(rs2, 0));
      chk("rnd_nb_busy1", {31'b0, busy1_nb}, {31'b0, m_busy(rs1, 0)});
      chk("rnd_nb_busy2", {31'b0, busy2_nb}, {31'b0, m_busy(rs2, 0)});
      chk("rnd_nb_ready", {31'b0, issue_ready_nb},
          {31'b0, (issue_rd == 0) || (m_pend[issue_rd] < 3)});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
